// File: rtl/sd_regs_pkg.sv
// rtl/sd_regs_pkg.sv - shared register indices, response type and state encodings
package sd_regs_pkg;

  localparam int REG_ARG   = 2;
  localparam int REG_CMD   = 3;
  localparam int REG_RESP0 = 4;
  localparam int REG_NIS   = 12;

  localparam logic [1:0] RESP_136 = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ARG,
    ST_WR_CMD,
    ST_POLL,
    ST_RD_RESP,
    ST_CLR,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_REQ,
    XF_REL
  } xfer_state_t;

endpackage

// File: rtl/sd_bus_xfer.sv
// rtl/sd_bus_xfer.sv - single-access 4-phase req/ack handshake engine with ack timeout
module sd_bus_xfer
  import sd_regs_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ACK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              go_rw,
  input  logic [ADDR_W-1:0] go_addr,
  input  logic [DATA_W-1:0] go_wdata,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic [DATA_W-1:0] xfer_rdata,
  output logic              req,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);

  localparam int CNT_W = $clog2(ACK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_MAX - 1);

  xfer_state_t      xs;
  logic [CNT_W-1:0] ack_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xs         <= XF_IDLE;
      ack_cnt    <= '0;
      req        <= 1'b0;
      rw         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
      xfer_rdata <= '0;
    end else begin
      xfer_done <= 1'b0;
      xfer_err  <= 1'b0;
      case (xs)
        XF_IDLE: if (go) begin
          req     <= 1'b1;
          rw      <= go_rw;
          addr    <= go_addr;
          wdata   <= go_wdata;
          ack_cnt <= '0;
          xs      <= XF_REQ;
        end
        XF_REQ: begin
          if (ack) begin
            if (rw) xfer_rdata <= rdata;
            req     <= 1'b0;
            ack_cnt <= '0;
            xs      <= XF_REL;
          end else if (ack_cnt == CNT_LAST) begin
            // req has been held ACK_MAX cycles with no ack: abandon the access
            req       <= 1'b0;
            xfer_done <= 1'b1;
            xfer_err  <= 1'b1;
            xs        <= XF_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        XF_REL: begin
          if (!ack) begin
            xfer_done <= 1'b1;
            xs        <= XF_IDLE;
          end else if (ack_cnt == CNT_LAST) begin
            xfer_done <= 1'b1;
            xfer_err  <= 1'b1;
            xs        <= XF_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        default: xs <= XF_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sd_cmd_issuer.sv
// rtl/sd_cmd_issuer.sv - issues one SD command over the host register bus and collects its response
module sd_cmd_issuer
  import sd_regs_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 1024,
  parameter int ACK_MAX  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       argument,
  input  logic [15:0]       command,
  input  logic [15:0]       transfer_mode,
  output logic              busy,
  output logic              done,
  output logic              cmd_timeout,
  output logic              bus_error,
  output logic [127:0]      response,
  output logic              req,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);

  localparam int PC_W = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_MAX - 1);

  state_t            state;
  logic              go, go_rw;
  logic [ADDR_W-1:0] go_addr;
  logic [DATA_W-1:0] go_wdata;
  logic              x_done, x_err;
  logic [DATA_W-1:0] x_rdata;
  logic [15:0]       cmd_q, tm_q;
  logic [PC_W-1:0]   poll_cnt;
  logic [1:0]        resp_idx;

  sd_bus_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_MAX(ACK_MAX)) u_xfer (
    .clk(clk), .reset(reset), .go(go), .go_rw(go_rw), .go_addr(go_addr), .go_wdata(go_wdata),
    .xfer_done(x_done), .xfer_err(x_err), .xfer_rdata(x_rdata),
    .req(req), .rw(rw), .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack)
  );

  // Each state launches its access via a one-cycle go and advances on the engine's done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      go          <= 1'b0;
      go_rw       <= 1'b0;
      go_addr     <= '0;
      go_wdata    <= '0;
      cmd_q       <= '0;
      tm_q        <= '0;
      poll_cnt    <= '0;
      resp_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_timeout <= 1'b0;
      bus_error   <= 1'b0;
      response    <= '0;
    end else begin
      go   <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          cmd_q       <= command;
          tm_q        <= transfer_mode;
          busy        <= 1'b1;
          response    <= '0;
          cmd_timeout <= 1'b0;
          bus_error   <= 1'b0;
          poll_cnt    <= '0;
          resp_idx    <= '0;
          go          <= 1'b1;
          go_rw       <= 1'b0;
          go_addr     <= ADDR_W'(REG_ARG);
          go_wdata    <= DATA_W'(argument);
          state       <= ST_WR_ARG;
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: if (x_done) begin
          if (x_err) begin
            bus_error <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FINISH;
          end else begin
            case (state)
              ST_WR_ARG: begin
                go       <= 1'b1;
                go_addr  <= ADDR_W'(REG_CMD);
                go_wdata <= DATA_W'({cmd_q, tm_q});
                state    <= ST_WR_CMD;
              end
              ST_WR_CMD: begin
                go      <= 1'b1;
                go_rw   <= 1'b1;
                go_addr <= ADDR_W'(REG_NIS);
                state   <= ST_POLL;
              end
              ST_POLL: begin
                go <= 1'b1;
                if (x_rdata[0]) begin
                  go_addr <= ADDR_W'(REG_RESP0);
                  state   <= ST_RD_RESP;
                end else if (poll_cnt == POLL_LAST) begin
                  cmd_timeout <= 1'b1;
                  go_rw       <= 1'b0;
                  go_wdata    <= '0;
                  state       <= ST_CLR;
                end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                end
              end
              ST_RD_RESP: begin
                response[32*resp_idx +: 32] <= x_rdata[31:0];
                go <= 1'b1;
                if (cmd_q[1:0] == RESP_136 && resp_idx != 2'd3) begin
                  resp_idx <= resp_idx + 1'b1;
                  go_addr  <= ADDR_W'(REG_RESP0) + ADDR_W'(resp_idx) + ADDR_W'(1);
                end else begin
                  go_rw    <= 1'b0;
                  go_addr  <= ADDR_W'(REG_NIS);
                  go_wdata <= '0;
                  state    <= ST_CLR;
                end
              end
              ST_CLR: begin
                done  <= 1'b1;
                state <= ST_FINISH;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
